// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX boundary.
// Covers control bundle, ID/EX register payload and the load-use source match.
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 4;
    localparam int CNT_W      = 16;

    typedef struct packed {
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data1;
        logic [XLEN-1:0]       data2;
        logic [XLEN-1:0]       imm;
        id_ex_ctrl_t           ctrl;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic logic src_hit(input logic used,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] rd);
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose rd (non-x0) is read by the ID instruction.
// Zero latency; no flow control of its own.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_valid,
    input  logic [1:0]            id_uses,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = src_hit(id_uses[0], id_rs1, ex_rd);
    assign rs2_hit  = src_hit(id_uses[1], id_rs2, ex_rd);
    assign load_use = ex_valid && ex_memread && (ex_rd != '0) && id_valid
                      && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall, flush bubbles and a saturating bubble counter.
// One-cycle capture latency; stall is combinational and holds PC and IF/ID upstream.
module id_ex_hazard_reg
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]       id_data1,
    input  logic [XLEN-1:0]       id_data2,
    input  logic [XLEN-1:0]       id_imm,
    input  id_ex_ctrl_t           id_ctrl,
    input  logic [1:0]            id_uses,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [XLEN-1:0]       ex_data1,
    output logic [XLEN-1:0]       ex_data2,
    output logic [XLEN-1:0]       ex_imm,
    output id_ex_ctrl_t           ex_ctrl,
    output logic                  stall,
    output logic [CNT_W-1:0]      bubble_count
);

    id_ex_t           ex_q;
    id_ex_t           capture;
    logic             load_use;
    logic [CNT_W-1:0] bubble_cnt;

    hazard_detect u_hazard_detect (
        .ex_valid   (ex_q.valid),
        .ex_memread (ex_q.ctrl.memread),
        .ex_rd      (ex_q.rd),
        .id_valid   (id_valid),
        .id_uses    (id_uses),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .load_use   (load_use)
    );

    // A flush kills the ID instruction anyway, so there is nothing to hold upstream.
    assign stall = load_use && !flush;

    always_comb begin
        capture       = '0;
        capture.valid = id_valid;
        capture.pc    = id_pc;
        capture.rs1   = id_rs1;
        capture.rs2   = id_rs2;
        capture.rd    = id_valid ? id_rd : '0;
        capture.data1 = id_data1;
        capture.data2 = id_data2;
        capture.imm   = id_imm;
        capture.ctrl  = id_valid ? id_ctrl : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q       <= ID_EX_BUBBLE;
            bubble_cnt <= '0;
        end else begin
            if (flush || load_use) begin
                ex_q <= ID_EX_BUBBLE;
            end else begin
                ex_q <= capture;
            end
            if (stall && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_data1     = ex_q.data1;
    assign ex_data2     = ex_q.data2;
    assign ex_imm       = ex_q.imm;
    assign ex_ctrl      = ex_q.ctrl;
    assign bubble_count = bubble_cnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: load-use stalls, flush priority, id_valid masking,
// counter saturation and reset during a stall.
module tb_id_ex_hazard_reg;
    import pipe_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [XLEN-1:0]       id_data1;
    logic [XLEN-1:0]       id_data2;
    logic [XLEN-1:0]       id_imm;
    id_ex_ctrl_t           id_ctrl;
    logic [1:0]            id_uses;
    logic                  flush;
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [XLEN-1:0]       ex_data1;
    logic [XLEN-1:0]       ex_data2;
    logic [XLEN-1:0]       ex_imm;
    id_ex_ctrl_t           ex_ctrl;
    logic                  stall;
    logic [CNT_W-1:0]      bubble_count;

    int n_assert = 0;
    int n_fail   = 0;

    id_ex_ctrl_t c_lw;
    id_ex_ctrl_t c_add;

    always #5 clk = ~clk;

    id_ex_hazard_reg dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_data1     (id_data1),
        .id_data2     (id_data2),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .id_uses      (id_uses),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_data1     (ex_data1),
        .ex_data2     (ex_data2),
        .ex_imm       (ex_imm),
        .ex_ctrl      (ex_ctrl),
        .stall        (stall),
        .bubble_count (bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm,
                         input id_ex_ctrl_t ctrl, input logic [1:0] uses);
        id_valid = v;
        id_pc    = pc;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_data1 = d1;
        id_data2 = d2;
        id_imm   = imm;
        id_ctrl  = ctrl;
        id_uses  = uses;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step;
        @(negedge clk);
        #1;
    endtask

    initial begin
        c_lw  = '{regwrite: 1'b1, memread: 1'b1, memwrite: 1'b0, memtoreg: 1'b1,
                  alusrc: 1'b1, aluop: 4'h0};
        c_add = '{regwrite: 1'b1, memread: 1'b0, memwrite: 1'b0, memtoreg: 1'b0,
                  alusrc: 1'b0, aluop: 4'h2};

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, '0, 2'b00);
        step();
        step();
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_ex_pc", ex_pc, 32'h0);
        chk("rst_bubble_count", 32'(bubble_count), 32'h0);
        reset = 1'b0;

        // lw x5, 8(x2)
        drive(1'b1, 32'h100, 5'd2, 5'd0, 5'd5, 32'h11, 32'h0, 32'h8, c_lw, 2'b01);
        #1;
        chk("post_rst_stall", 32'(stall), 32'h0);
        step();
        chk("lw_ex_valid", 32'(ex_valid), 32'h1);
        chk("lw_ex_rd", 32'(ex_rd), 32'h5);
        chk("lw_ex_ctrl", 32'(ex_ctrl), 32'(c_lw));
        chk("lw_ex_imm", ex_imm, 32'h8);

        // add x6, x5, x7 depends on the load
        drive(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 32'hAAAA, 32'hBBBB, 32'h0, c_add, 2'b11);
        #1;
        chk("lu_stall", 32'(stall), 32'h1);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
        chk("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        chk("lu_bubble_rd", 32'(ex_rd), 32'h0);
        chk("lu_bubble_pc", ex_pc, 32'h0);
        chk("lu_bubble_count", 32'(bubble_count), 32'h1);
        chk("lu_stall_released", 32'(stall), 32'h0);
        step();
        chk("add_ex_valid", 32'(ex_valid), 32'h1);
        chk("add_ex_pc", ex_pc, 32'h104);
        chk("add_ex_data1", ex_data1, 32'hAAAA);
        chk("add_ex_data2", ex_data2, 32'hBBBB);
        chk("add_ex_rs2", 32'(ex_rs2), 32'h7);
        chk("add_bubble_count", 32'(bubble_count), 32'h1);

        // lw x0 followed by a reader of x0
        drive(1'b1, 32'h200, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, c_lw, 2'b01);
        step();
        drive(1'b1, 32'h204, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, c_add, 2'b01);
        #1;
        chk("x0_stall", 32'(stall), 32'h0);
        step();
        chk("x0_ex_pc", ex_pc, 32'h204);
        chk("x0_ex_valid", 32'(ex_valid), 32'h1);
        chk("x0_bubble_count", 32'(bubble_count), 32'h1);

        // lw x5 then an instruction whose rs2=5 is not actually read
        drive(1'b1, 32'h300, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw, 2'b01);
        step();
        drive(1'b1, 32'h304, 5'd1, 5'd5, 5'd4, 32'h0, 32'h0, 32'h0, c_add, 2'b01);
        #1;
        chk("unused_rs2_stall", 32'(stall), 32'h0);
        step();
        chk("unused_rs2_ex_pc", ex_pc, 32'h304);
        chk("unused_rs2_ex_rd", 32'(ex_rd), 32'h4);

        // invalid ID slot: ctrl and rd masked, other fields still captured
        drive(1'b0, 32'h400, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, c_lw, 2'b11);
        step();
        chk("inv_ex_valid", 32'(ex_valid), 32'h0);
        chk("inv_ex_ctrl", 32'(ex_ctrl), 32'h0);
        chk("inv_ex_rd", 32'(ex_rd), 32'h0);
        chk("inv_ex_pc", ex_pc, 32'h400);

        // flush coincident with a load-use hazard
        drive(1'b1, 32'h500, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw, 2'b01);
        step();
        drive(1'b1, 32'h504, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, c_add, 2'b01);
        flush = 1'b1;
        #1;
        chk("flush_lu_stall", 32'(stall), 32'h0);
        step();
        flush = 1'b0;
        chk("flush_ex_valid", 32'(ex_valid), 32'h0);
        chk("flush_ex_pc", ex_pc, 32'h0);
        chk("flush_bubble_count", 32'(bubble_count), 32'h1);

        // saturation from 16'hFFFE
        force dut.bubble_cnt = 16'hFFFE;
        #1;
        release dut.bubble_cnt;
        #1;
        chk("sat_preload", 32'(bubble_count), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h600, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw, 2'b01);
            step();
            drive(1'b1, 32'h604, 5'd0, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, c_add, 2'b10);
            #1;
            chk("sat_stall", 32'(stall), 32'h1);
            step();
            chk("sat_bubble_count", 32'(bubble_count), 32'hFFFF);
        end

        // reset arriving while a stall is pending
        drive(1'b1, 32'h700, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw, 2'b01);
        step();
        drive(1'b1, 32'h704, 5'd5, 5'd0, 5'd6, 32'h1, 32'h2, 32'h3, c_add, 2'b01);
        #1;
        chk("pre_rst_stall", 32'(stall), 32'h1);
        reset = 1'b1;
        step();
        chk("midrst_ex_valid", 32'(ex_valid), 32'h0);
        chk("midrst_ex_pc", ex_pc, 32'h0);
        chk("midrst_ex_rd", 32'(ex_rd), 32'h0);
        chk("midrst_ex_ctrl", 32'(ex_ctrl), 32'h0);
        chk("midrst_ex_data1", ex_data1, 32'h0);
        chk("midrst_bubble_count", 32'(bubble_count), 32'h0);
        chk("midrst_stall", 32'(stall), 32'h0);
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
ID_EX_HAZARD_REG -- requirements
Module: id_ex_hazard_reg

Interface
REQ-001 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port id_valid  in  1  ID-stage instruction valid.
REQ-004 SHALL have port id_pc  in  32  ID-stage PC.
REQ-005 SHALL have port id_rs1  in  5  source register 1 address.
REQ-006 SHALL have port id_rs2  in  5  source register 2 address.
REQ-007 SHALL have port id_rd  in  5  destination register address.
REQ-008 SHALL have port id_data1  in  32  register-file read data 1.
REQ-009 SHALL have port id_data2  in  32  register-file read data 2.
REQ-010 SHALL have port id_imm  in  32  sign-extended immediate.
REQ-011 SHALL have port id_ctrl  in  id_ex_ctrl_t  {regwrite, memread, memwrite, memtoreg, alusrc, aluop[3:0]}.
REQ-012 SHALL have port id_uses  in  2  bit0: instruction reads rs1; bit1: instruction reads rs2.
REQ-013 SHALL have port flush  in  1  branch/jump taken in EX; kill ID instruction.
REQ-014 SHALL have ports ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2, ex_imm, ex_ctrl  out  same widths as the ID counterparts  registered ID/EX contents; ex_rs1/ex_rs2/ex_rd feed the forwarding unit.
REQ-015 SHALL have port stall  out  1  combinational; holds PC and IF/ID register.
REQ-016 SHALL have port bubble_count  out  16  number of load-use bubbles inserted, saturating.

Function
REQ-017 SHALL compute load_use = ex_valid & ex_ctrl.memread & (ex_rd!=0) & id_valid & ((id_uses[0] & id_rs1==ex_rd) | (id_uses[1] & id_rs2==ex_rd)).
REQ-018 SHALL drive stall = load_use & ~flush, combinationally in the same cycle.
REQ-019 SHALL insert a bubble at the next edge when flush=1, or when load_use=1: ex_valid=0, ex_ctrl all zero, ex_rd/ex_rs1/ex_rs2=0, ex_data1/ex_data2/ex_imm/ex_pc=0.
REQ-020 SHALL give flush priority over load_use; flush with load_use yields a bubble, stall=0, no bubble_count increment.
REQ-021 SHALL otherwise capture all ID fields with a latency of 1 cycle; if id_valid=0, ex_ctrl SHALL be forced to zero and ex_rd to 0.
REQ-022 SHALL insert at most one consecutive load-use bubble per load, since the bubble clears ex_ctrl.memread.
REQ-023 SHALL never stall for rd=x0, or for an unused source field (id_uses bit clear).
REQ-024 SHALL increment bubble_count by 1 on each load-use bubble (not flush bubble), holding at 16'hFFFF.

Reset
REQ-025 SHALL, while reset=1 at a rising edge, clear every registered output (ex_* = 0, ex_valid=0, bubble_count=0); reset SHALL override flush and load_use.
REQ-026 SHALL drive stall=0 in the first cycle after reset, since ex_valid=0.

Structure
REQ-027 SHALL place id_ex_ctrl_t, XLEN=32, REG_ADDR_W=5 and ALUOP_W=4 in shared package pipe_pkg.
REQ-028 SHALL implement the load-use comparison as combinational sub-module hazard_detect; the ID/EX register and the counter SHALL be in id_ex_hazard_reg.

Verification
REQ-029 Verification SHALL cover: lw x5 in EX (ex_memread=1, ex_rd=5), ID add x6,x5,x7 uses=2'b11 -> stall=1, next edge ex_valid=0, bubble_count=1, and the following cycle stall=0 with add captured.
REQ-030 Verification SHALL cover: lw x0 in EX, ID rs1=0 -> stall=0 and no bubble.
REQ-031 Verification SHALL cover: lw x5 in EX, ID instruction with rs2=5 and uses=2'b01 -> stall=0, instruction captured next cycle.
REQ-032 Verification SHALL cover: flush=1 together with load_use=1 -> stall=0, bubble inserted, bubble_count unchanged.
REQ-033 Verification SHALL cover: force bubble_count=16'hFFFE, apply three load-use events -> bubble_count=16'hFFFF and held.
REQ-034 Verification SHALL cover: reset asserted mid-stall -> next edge all ex_* = 0, bubble_count=0, stall=0.
